lif_neuron_sched: RTL and testbench
===================================

LIF_NEURON_SCHED -- requirements
Module: lif_neuron_sched

Interface
REQ-001 Parameter N_NEURON, default 4, number of time-multiplexed virtual neurons (power of two, 2..8).
REQ-002 Parameter W, default 8, membrane/current/threshold width in bits.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 cfg_we  input  1  configuration write strobe.
REQ-006 cfg_addr  input  2  config register select: 0 threshold, 1 leak_shift, 2 refr_period, 3 enable_mask.
REQ-007 cfg_data  input  W  configuration write data.
REQ-008 start  input  1  request begin of continuous sweeps.
REQ-009 stop  input  1  request halt after current sweep.
REQ-010 cur_in  input  W  input current for the neuron selected by cur_sel, sampled same cycle.
REQ-011 cur_sel  output  log2(N_NEURON)  index of neuron being served (combinational from FSM index).
REQ-012 v_out  output  W  registered membrane value of last served neuron.
REQ-013 spike_out  output  1  registered one-cycle spike pulse for last served neuron.
REQ-014 spike_id  output  log2(N_NEURON)  registered index qualifying v_out/spike_out.
REQ-015 busy  output  1  high in RUN and SYNC.
REQ-016 sweep_done  output  1  one-cycle pulse in SYNC.

Function
REQ-017 FSM states IDLE, RUN, SYNC; IDLE->RUN on start; RUN->SYNC when idx = N_NEURON-1; SYNC->RUN if no pending stop, else SYNC->IDLE.
REQ-018 In RUN, one neuron served per cycle, idx 0..N_NEURON-1 ascending; sweep period N_NEURON+1 cycles.
REQ-019 Update for enabled, non-refractory neuron: v_next = saturate_W(cur_in + (v >> leak_shift)); leak_shift 0 means v_next = sat(cur_in + v).
REQ-020 Spike when v_next >= threshold; then stored v := 0, refr counter := refr_period, spike_out = 1, v_out = v_next (pre-reset value).
REQ-021 Refractory neuron (counter > 0): v held 0, counter decrements by 1, cur_in ignored, no spike.
REQ-022 Disabled neuron (enable_mask bit 0): slot still consumed, v and counter held, no spike, v_out = held v.
REQ-023 Outputs v_out/spike_out/spike_id registered: valid the cycle after cur_sel = idx (latency 1).
REQ-024 Outside RUN-output cycle spike_out = 0; v_out/spike_id hold last value.
REQ-025 Config writes accepted only in IDLE; writes in RUN/SYNC ignored.
REQ-026 stop latched in RUN/SYNC; sweep always completes; latch cleared on entry to IDLE.
REQ-027 start and stop together in IDLE: exactly one sweep, then IDLE.
REQ-028 threshold = 0: every enabled non-refractory neuron spikes every serve.
REQ-029 Saturation: sum clamped to 2^W-1, no wrap-around.
REQ-030 Only low N_NEURON bits of enable_mask used; leak_shift uses low 3 bits.

Reset
REQ-031 On rst: state IDLE, idx 0, stop latch 0, all membranes 0, all refr counters 0.
REQ-032 On rst: threshold 128, leak_shift 1, refr_period 0, enable_mask all ones.
REQ-033 On rst: v_out 0, spike_out 0, spike_id 0, busy 0, sweep_done 0; rst mid-sweep aborts immediately, no sweep_done.

Structure
REQ-034 Shared package lif_pkg holds cfg address constants, FSM state enum, reset-value constants.
REQ-035 Combinational update datapath (shift, saturating add, compare) in sub-module lif_update; scheduler holds state arrays and FSM.

Verification
REQ-036 Reset defaults, start, cur_in=100 to all, 2 sweeps -> sweep 1 v_out=100 no spike; sweep 2 v_out=150 (100+50) spike_out=1 each id, stored v=0.
REQ-037 refr_period=2, threshold=10, cur_in=20 -> spike sweep 1, no spike sweeps 2-3 (v_out=0), spike again sweep 4.
REQ-038 cur_in=255, leak_shift=0, threshold=255 -> sweep 1 v_out=255 spike; threshold 0 -> spike every serve.
REQ-039 enable_mask=4'b0101 -> ids 1,3 never spike, v_out=0; cur_sel still visits 0..3; sweep_done every 5 cycles.
REQ-040 stop at sweep cycle 2 -> sweep finishes, sweep_done pulses, IDLE next; cfg_we during RUN leaves threshold unchanged.
REQ-041 rst asserted at idx 2 -> next cycle IDLE, all outputs reset values, no sweep_done.

Source files
------------

// File: rtl/lif_pkg.sv
// Shared definitions for the time-multiplexed LIF neuron scheduler.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
// Contents: config register addresses, scheduler state encoding, reset values.
package lif_pkg;

   // Configuration register select values
   localparam logic [1:0] CFG_THRESHOLD   = 2'd0;
   localparam logic [1:0] CFG_LEAK_SHIFT  = 2'd1;
   localparam logic [1:0] CFG_REFR_PERIOD = 2'd2;
   localparam logic [1:0] CFG_ENABLE_MASK = 2'd3;

   // Scheduler states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_SYNC = 2'd2
   } state_t;

   // Configuration values loaded on reset (enable mask resets to all ones)
   localparam int RST_THRESHOLD   = 128;
   localparam int RST_LEAK_SHIFT  = 1;
   localparam int RST_REFR_PERIOD = 0;

endpackage

// File: rtl/lif_update.sv
// Combinational single-neuron LIF update: leak shift, saturating add, threshold compare.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; result is consumed by the scheduler in the same cycle.
// Ports: v_i/refr_i current neuron state, cur_i input current, config inputs;
//        v_store_o/refr_o next stored state, v_report_o value to publish, spike_o spike flag.
module lif_update #(
   parameter int W = 8
) (
   input  logic [W-1:0] v_i,
   input  logic [W-1:0] refr_i,
   input  logic [W-1:0] cur_i,
   input  logic [2:0]   leak_shift_i,
   input  logic [W-1:0] threshold_i,
   input  logic [W-1:0] refr_period_i,
   input  logic         enable_i,
   output logic [W-1:0] v_store_o,
   output logic [W-1:0] refr_o,
   output logic [W-1:0] v_report_o,
   output logic         spike_o
);

   logic [W-1:0] leaked;
   logic [W:0]   sum;
   logic [W-1:0] v_next;

   always_comb begin
      leaked = v_i >> leak_shift_i;
      // One extra bit catches the carry so the sum clamps instead of wrapping
      sum    = {1'b0, cur_i} + {1'b0, leaked};
      v_next = sum[W] ? {W{1'b1}} : sum[W-1:0];

      // Disabled neuron: everything held, held value is reported
      v_store_o  = v_i;
      refr_o     = refr_i;
      v_report_o = v_i;
      spike_o    = 1'b0;

      if (enable_i) begin
         if (refr_i != '0) begin
            // Refractory: membrane pinned at 0, input ignored
            v_store_o  = '0;
            refr_o     = refr_i - 1'b1;
            v_report_o = '0;
         end else begin
            v_report_o = v_next;
            if (v_next >= threshold_i) begin
               spike_o   = 1'b1;
               v_store_o = '0;
               refr_o    = refr_period_i;
            end else begin
               v_store_o = v_next;
            end
         end
      end
   end

endmodule

// File: rtl/lif_neuron_sched.sv
// Scheduler serving N_NEURON virtual LIF neurons, one per cycle, in sweeps of N_NEURON+1 cycles.
// Latency: v_out/spike_out/spike_id valid 1 cycle after cur_sel selects the neuron.
// Backpressure: none; cur_in is sampled every RUN cycle, stop only takes effect at sweep end.
// Ports: cfg_we/cfg_addr/cfg_data config (IDLE only), start/stop control, cur_in current,
//        cur_sel served index, v_out/spike_out/spike_id result, busy, sweep_done.
module lif_neuron_sched
   import lif_pkg::*;
#(
   parameter int N_NEURON = 4,
   parameter int W        = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        cfg_we,
   input  logic [1:0]                  cfg_addr,
   input  logic [W-1:0]                cfg_data,
   input  logic                        start,
   input  logic                        stop,
   input  logic [W-1:0]                cur_in,
   output logic [$clog2(N_NEURON)-1:0] cur_sel,
   output logic [W-1:0]                v_out,
   output logic                        spike_out,
   output logic [$clog2(N_NEURON)-1:0] spike_id,
   output logic                        busy,
   output logic                        sweep_done
);

   localparam int IW = $clog2(N_NEURON);
   localparam logic [IW-1:0] LAST_IDX = IW'(N_NEURON - 1);

   state_t              state_q;
   logic [IW-1:0]       idx_q;
   logic                stop_q;
   logic [W-1:0]        threshold_q;
   logic [2:0]          leak_shift_q;
   logic [W-1:0]        refr_period_q;
   logic [N_NEURON-1:0] enable_q;
   logic [W-1:0]        v_q    [N_NEURON];
   logic [W-1:0]        refr_q [N_NEURON];

   logic [W-1:0]        v_d;
   logic [W-1:0]        refr_d;
   logic [W-1:0]        v_rep_d;
   logic                spike_d;

   lif_update #(.W(W)) u_update (
      .v_i           (v_q[idx_q]),
      .refr_i        (refr_q[idx_q]),
      .cur_i         (cur_in),
      .leak_shift_i  (leak_shift_q),
      .threshold_i   (threshold_q),
      .refr_period_i (refr_period_q),
      .enable_i      (enable_q[idx_q]),
      .v_store_o     (v_d),
      .refr_o        (refr_d),
      .v_report_o    (v_rep_d),
      .spike_o       (spike_d)
   );

   assign cur_sel    = idx_q;
   assign busy       = (state_q != ST_IDLE);
   assign sweep_done = (state_q == ST_SYNC);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         idx_q         <= '0;
         stop_q        <= 1'b0;
         threshold_q   <= W'(RST_THRESHOLD);
         leak_shift_q  <= 3'(RST_LEAK_SHIFT);
         refr_period_q <= W'(RST_REFR_PERIOD);
         enable_q      <= '1;
         v_out         <= '0;
         spike_out     <= 1'b0;
         spike_id      <= '0;
         for (int i = 0; i < N_NEURON; i++) begin
            v_q[i]    <= '0;
            refr_q[i] <= '0;
         end
      end else begin
         spike_out <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (cfg_we) begin
                  case (cfg_addr)
                     CFG_THRESHOLD:   threshold_q   <= cfg_data;
                     CFG_LEAK_SHIFT:  leak_shift_q  <= cfg_data[2:0];
                     CFG_REFR_PERIOD: refr_period_q <= cfg_data;
                     CFG_ENABLE_MASK: enable_q      <= cfg_data[N_NEURON-1:0];
                     default: ;
                  endcase
               end
               if (start) begin
                  state_q <= ST_RUN;
                  idx_q   <= '0;
                  // start+stop together yields exactly one sweep
                  stop_q  <= stop;
               end
            end
            ST_RUN: begin
               v_q[idx_q]    <= v_d;
               refr_q[idx_q] <= refr_d;
               v_out         <= v_rep_d;
               spike_out     <= spike_d;
               spike_id      <= idx_q;
               if (stop) stop_q <= 1'b1;
               // Power-of-two neuron count: index wraps to 0 for the next sweep
               idx_q <= idx_q + 1'b1;
               if (idx_q == LAST_IDX) state_q <= ST_SYNC;
            end
            ST_SYNC: begin
               if (stop_q || stop) begin
                  state_q <= ST_IDLE;
                  stop_q  <= 1'b0;
               end else begin
                  state_q <= ST_RUN;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lif_neuron_sched.sv
module tb_lif_neuron_sched;

   localparam int N = 4;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         cfg_we;
   logic [1:0]   cfg_addr;
   logic [W-1:0] cfg_data;
   logic         start;
   logic         stop;
   logic [W-1:0] cur_in;
   logic [1:0]   cur_sel;
   logic [W-1:0] v_out;
   logic         spike_out;
   logic [1:0]   spike_id;
   logic         busy;
   logic         sweep_done;

   always #5 clk = ~clk;

   lif_neuron_sched #(.N_NEURON(N), .W(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_we     (cfg_we),
      .cfg_addr   (cfg_addr),
      .cfg_data   (cfg_data),
      .start      (start),
      .stop       (stop),
      .cur_in     (cur_in),
      .cur_sel    (cur_sel),
      .v_out      (v_out),
      .spike_out  (spike_out),
      .spike_id   (spike_id),
      .busy       (busy),
      .sweep_done (sweep_done)
   );

   int n_vec = 0;
   int n_mis = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_mis++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   // Sweep position: -1 idle, 0..N-1 serving that neuron, N = end-of-sweep slot.
   int m_v[N];
   int m_r[N];
   int m_thr, m_ls, m_rp, m_en;
   int m_pos;
   bit m_stop;
   int m_vout, m_id;

   function automatic void model_reset();
      for (int i = 0; i < N; i++) begin
         m_v[i] = 0;
         m_r[i] = 0;
      end
      m_thr = 128; m_ls = 1; m_rp = 0; m_en = 15;
      m_pos = -1; m_stop = 0; m_vout = 0; m_id = 0;
   endfunction

   // Apply the LIF rule to neuron n; returns the spike flag
   function automatic bit serve(input int n, input int cur);
      int s;
      m_id = n;
      if (((m_en >> n) & 1) == 0) begin
         m_vout = m_v[n];
         return 1'b0;
      end
      if (m_r[n] > 0) begin
         m_r[n]--;
         m_v[n] = 0;
         m_vout = 0;
         return 1'b0;
      end
      s = cur + (m_v[n] >> m_ls);
      if (s > 255) s = 255;
      m_vout = s;
      if (s >= m_thr) begin
         m_v[n] = 0;
         m_r[n] = m_rp;
         return 1'b1;
      end
      m_v[n] = s;
      return 1'b0;
   endfunction

   // One clock with the currently driven inputs, checked against the model
   task automatic m_tick();
      bit e_spk;
      e_spk = 1'b0;
      if (m_pos < N) chk("cur_sel", int'(cur_sel), (m_pos < 0) ? 0 : m_pos);
      if (m_pos < 0) begin
         if (cfg_we) begin
            case (int'(cfg_addr))
               0: m_thr = int'(cfg_data);
               1: m_ls  = int'(cfg_data) & 7;
               2: m_rp  = int'(cfg_data);
               default: m_en = int'(cfg_data) & 15;
            endcase
         end
         if (start) begin
            m_pos  = 0;
            m_stop = stop;
         end
      end else if (m_pos < N) begin
         e_spk = serve(m_pos, int'(cur_in));
         if (stop) m_stop = 1'b1;
         m_pos++;
      end else begin
         if (m_stop || stop) begin
            m_pos  = -1;
            m_stop = 1'b0;
         end else begin
            m_pos = 0;
         end
      end
      @(posedge clk); #1;
      chk("busy", int'(busy), (m_pos != -1) ? 1 : 0);
      chk("sweep_done", int'(sweep_done), (m_pos == N) ? 1 : 0);
      chk("spike_out", int'(spike_out), int'(e_spk));
      chk("v_out", int'(v_out), m_vout);
      chk("spike_id", int'(spike_id), m_id);
   endtask

   task automatic clear_inputs();
      cfg_we = 1'b0; cfg_addr = 2'd0; cfg_data = '0;
      start = 1'b0; stop = 1'b0; cur_in = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      chk("rst_busy", int'(busy), 0);
      chk("rst_sweep_done", int'(sweep_done), 0);
      chk("rst_spike_out", int'(spike_out), 0);
      chk("rst_v_out", int'(v_out), 0);
      chk("rst_spike_id", int'(spike_id), 0);
      chk("rst_cur_sel", int'(cur_sel), 0);
   endtask

   task automatic cfg_write(input int addr, input int data);
      cfg_we = 1'b1; cfg_addr = 2'(addr); cfg_data = 8'(data);
      m_tick();
      cfg_we = 1'b0;
   endtask

   int spk_log[8][N];
   int v_log[8][N];

   // Exactly n sweeps; cur < 0 means random current each serve
   task automatic run_sweeps(input int n, input int cur);
      start = 1'b1; stop = (n == 1);
      m_tick();
      start = 1'b0; stop = 1'b0;
      for (int s = 0; s < n; s++) begin
         for (int k = 0; k < N; k++) begin
            cur_in = (cur < 0) ? 8'($urandom_range(255)) : 8'(cur);
            stop = (n > 1 && s == n - 1 && k == 0);
            m_tick();
            spk_log[s][k] = int'(spike_out);
            v_log[s][k]   = int'(v_out);
         end
         stop = 1'b0;
         m_tick();
      end
      chk("idle_after_sweeps", int'(busy), 0);
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      int st, sp, cur;
      int busy, sd, spk, v, id;
   } vec_t;

   vec_t tbl[17];

   function automatic vec_t mk(input int st, input int sp, input int cur, input int b,
                               input int sd, input int spk, input int v, input int id);
      vec_t r;
      r.st = st; r.sp = sp; r.cur = cur; r.busy = b; r.sd = sd; r.spk = spk; r.v = v; r.id = id;
      return r;
   endfunction

   initial begin
      rst = 1'b1;
      clear_inputs();
      repeat (2) @(posedge clk);
      #1;
      do_reset();

      // Defaults (thr 128, leak 1): sweep 1 -> 100, sweep 2 -> 150 spiking, then stored v is 0
      tbl[0]  = mk(1, 0, 100, 1, 0, 0,   0, 0);
      tbl[1]  = mk(0, 0, 100, 1, 0, 0, 100, 0);
      tbl[2]  = mk(0, 0, 100, 1, 0, 0, 100, 1);
      tbl[3]  = mk(0, 0, 100, 1, 0, 0, 100, 2);
      tbl[4]  = mk(0, 0, 100, 1, 1, 0, 100, 3);
      tbl[5]  = mk(0, 0, 100, 1, 0, 0, 100, 3);
      tbl[6]  = mk(0, 1, 100, 1, 0, 1, 150, 0);
      tbl[7]  = mk(0, 0, 100, 1, 0, 1, 150, 1);
      tbl[8]  = mk(0, 0, 100, 1, 0, 1, 150, 2);
      tbl[9]  = mk(0, 0, 100, 1, 1, 1, 150, 3);
      tbl[10] = mk(0, 0, 100, 0, 0, 0, 150, 3);
      tbl[11] = mk(1, 1, 100, 1, 0, 0, 150, 3);
      tbl[12] = mk(0, 0, 100, 1, 0, 0, 100, 0);
      tbl[13] = mk(0, 0, 100, 1, 0, 0, 100, 1);
      tbl[14] = mk(0, 0, 100, 1, 0, 0, 100, 2);
      tbl[15] = mk(0, 0, 100, 1, 1, 0, 100, 3);
      tbl[16] = mk(0, 0, 100, 0, 0, 0, 100, 3);
      for (int i = 0; i < 17; i++) begin
         start = 1'(tbl[i].st); stop = 1'(tbl[i].sp); cur_in = 8'(tbl[i].cur);
         @(posedge clk); #1;
         chk($sformatf("tbl%0d_busy", i), int'(busy), tbl[i].busy);
         chk($sformatf("tbl%0d_sweep_done", i), int'(sweep_done), tbl[i].sd);
         chk($sformatf("tbl%0d_spike", i), int'(spike_out), tbl[i].spk);
         chk($sformatf("tbl%0d_v_out", i), int'(v_out), tbl[i].v);
         chk($sformatf("tbl%0d_spike_id", i), int'(spike_id), tbl[i].id);
      end

      // Refractory: spike, two silent sweeps at 0, spike again
      do_reset();
      cfg_write(2, 2);
      cfg_write(0, 10);
      run_sweeps(4, 20);
      for (int k = 0; k < N; k++) begin
         chk("refr_s1_spike", spk_log[0][k], 1);
         chk("refr_s1_v", v_log[0][k], 20);
         chk("refr_s2_spike", spk_log[1][k], 0);
         chk("refr_s2_v", v_log[1][k], 0);
         chk("refr_s3_spike", spk_log[2][k], 0);
         chk("refr_s4_spike", spk_log[3][k], 1);
      end

      // Saturation at full scale, then threshold 0 spikes every serve
      do_reset();
      cfg_write(1, 0);
      cfg_write(0, 255);
      run_sweeps(1, 255);
      for (int k = 0; k < N; k++) begin
         chk("sat_v", v_log[0][k], 255);
         chk("sat_spike", spk_log[0][k], 1);
      end
      cfg_write(0, 0);
      run_sweeps(2, 0);
      for (int k = 0; k < N; k++) begin
         chk("thr0_s1_spike", spk_log[0][k], 1);
         chk("thr0_s2_spike", spk_log[1][k], 1);
      end

      // Enable mask 0101: odd neurons silent and held at 0
      do_reset();
      cfg_write(3, 5);
      run_sweeps(2, 200);
      for (int s = 0; s < 2; s++) begin
         chk("mask_id0_spike", spk_log[s][0], 1);
         chk("mask_id1_spike", spk_log[s][1], 0);
         chk("mask_id1_v", v_log[s][1], 0);
         chk("mask_id2_spike", spk_log[s][2], 1);
         chk("mask_id3_spike", spk_log[s][3], 0);
         chk("mask_id3_v", v_log[s][3], 0);
      end

      // Stop at sweep cycle 2 with an ignored config write in the same cycle
      do_reset();
      start = 1'b1; m_tick(); start = 1'b0;
      cur_in = 8'd30;
      m_tick();
      m_tick();
      stop = 1'b1; cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = 8'd0;
      m_tick();
      stop = 1'b0; cfg_we = 1'b0;
      m_tick();
      chk("stop_sweep_done", int'(sweep_done), 1);
      m_tick();
      chk("stop_idle", int'(busy), 0);
      run_sweeps(1, 100);
      for (int k = 0; k < N; k++) begin
         chk("thr_kept_spike", spk_log[0][k], 0);
         chk("thr_kept_v", v_log[0][k], 115);
      end

      // Reset mid-sweep at idx 2
      do_reset();
      start = 1'b1; m_tick(); start = 1'b0;
      cur_in = 8'd50;
      m_tick();
      m_tick();
      chk("sel_before_rst", int'(cur_sel), 2);
      do_reset();
      run_sweeps(1, 100);
      chk("membrane_cleared", v_log[0][0], 100);

      // Randomized traffic against the model
      do_reset();
      for (int i = 0; i < 800; i++) begin
         start  = ($urandom_range(7) == 0);
         stop   = ($urandom_range(9) == 0);
         cfg_we = ($urandom_range(5) == 0);
         cfg_addr = 2'($urandom_range(3));
         cfg_data = 8'($urandom_range(255));
         if (cfg_addr == 2'd2) cfg_data = 8'($urandom_range(3));
         cur_in = 8'($urandom_range(255));
         m_tick();
      end
      clear_inputs();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
